// File: rtl/ram_burst_master_if.sv
// Client and RAM-control signals of the burst master, grouped as one bundle.
// The shared RAM data bus stays a separate inout net on the master.
interface ram_burst_master_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 4
);
  logic                  reqValid;
  logic                  reqReady;
  logic                  reqWrite;
  logic [ADDR_WIDTH-1:0] reqAddr;
  logic [LEN_WIDTH-1:0]  reqLen;
  logic                  wrValid;
  logic [0:DATA_WIDTH-1] wrData;
  logic                  wrReady;
  logic                  rdValid;
  logic [0:DATA_WIDTH-1] rdData;
  logic                  rdLast;
  logic                  done;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] address;
  logic                  isReading;

  modport master (
    input  reqValid, reqWrite, reqAddr, reqLen, wrValid, wrData,
    output reqReady, wrReady, rdValid, rdData, rdLast, done, busy, address, isReading
  );

  modport slave (
    output reqValid, reqWrite, reqAddr, reqLen, wrValid, wrData,
    input  reqReady, wrReady, rdValid, rdData, rdLast, done, busy, address, isReading
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM: converts client read/write
// bursts into address/isReading cycles on a shared bidirectional data bus.
module ram_burst_master #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_burst_master_if.master    bus,
  inout  wire  [0:DATA_WIDTH-1] data
);

  typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  req_len_clamped;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic                  done_q, done_d;
  logic [0:DATA_WIDTH-1] rd_data_q, rd_data_d;
  logic                  wr_fire;

  // The RAM writes on any edge with isReading low, so the bus is only
  // turned around while a write word is actually being offered.
  assign wr_fire       = bus.wrValid && (state_q == WR);
  assign bus.wrReady   = wr_fire;
  assign bus.isReading = ~wr_fire;
  assign data          = wr_fire ? bus.wrData : 'z;

  assign bus.reqReady = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.address  = cur_q;
  assign bus.rdValid  = rd_valid_q;
  assign bus.rdLast   = rd_last_q;
  assign bus.rdData   = rd_data_q;
  assign bus.done     = done_q;

  assign req_len_clamped = (bus.reqLen > LEN_WIDTH'(MAX_BURST)) ? LEN_WIDTH'(MAX_BURST)
                                                                : bus.reqLen;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    done_d     = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          cur_d = bus.reqAddr;
          len_d = req_len_clamped;
          cnt_d = '0;
          if (req_len_clamped == '0) state_d = FIN;
          else if (bus.reqWrite)     state_d = WR;
          else                       state_d = RD;
        end
      end
      RD: begin
        // Word issued at the previous edge is on the bus this cycle.
        if (cnt_q != '0) begin
          rd_valid_d = 1'b1;
          rd_data_d  = data;
        end
        cur_d = cur_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == len_q) state_d = RD_TAIL;
      end
      RD_TAIL: begin
        rd_valid_d = 1'b1;
        rd_last_d  = 1'b1;
        done_d     = 1'b1;
        rd_data_d  = data;
        state_d    = IDLE;
      end
      WR: begin
        if (bus.wrValid) begin
          cur_d = cur_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 2048x64 RAM on the
// shared bus; expectations are queued by the stimulus and checked by a monitor.
module tb_ram_burst_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_burst_master_if bus_if ();
  wire [0:63] data;

  ram_burst_master #(.ADDR_WIDTH(11), .DATA_WIDTH(64), .MAX_BURST(8), .LEN_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .data  (data)
  );

  // Behavioural RAM: registers a read word at each isReading edge and drives it
  // in the following cycle; writes data at each edge with isReading low.
  logic [0:63] mem [0:2047];
  logic [0:63] exp_mem [0:2047];
  logic [0:63] ram_q;
  logic        ram_oe_q;
  logic        ram_out_en = 1'b1;
  logic        ram_init   = 1'b1;

  function automatic logic [0:63] init_word(input int i);
    return {32'h5EED0000 ^ 32'(i), 32'(i) * 32'h9E3779B9};
  endfunction

  function automatic logic [0:63] mkword(input int k);
    return {32'hC0DE0000 + 32'(k), 32'h12345678 ^ (32'(k) << 8)};
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
    end else begin
      ram_oe_q <= bus_if.isReading;
      ram_q    <= mem[bus_if.address];
      if (!bus_if.isReading) mem[bus_if.address] <= data;
    end
  end

  assign data = (ram_out_en && ram_oe_q && bus_if.isReading) ? ram_q : 'z;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {logic [0:63] d; logic last; int c;} rd_exp_t;
  typedef struct packed {logic [10:0] a; logic [0:63] d;} wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      done_q[$];

  // Monitor: samples 2 time units after the falling edge.
  always @(negedge clk) begin
    #2;
    if (bus_if.rdValid) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 64'(bus_if.rdValid), 64'd0);
      else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk("rd_data", bus_if.rdData, e.d);
        chk("rd_last", 64'(bus_if.rdLast), 64'(e.last));
        chk("rd_cycle", 64'(cyc), 64'(e.c));
      end
    end
    if (bus_if.done) begin
      if (done_q.size() == 0) chk("done_unexpected", 64'(bus_if.done), 64'd0);
      else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
    end
    if (!bus_if.isReading) begin
      if (wr_q.size() == 0) chk("ram_write_unexpected", 64'(bus_if.isReading), 64'd1);
      else begin
        wr_exp_t w;
        w = wr_q.pop_front();
        chk("wr_addr", 64'(bus_if.address), 64'(w.a));
        chk("wr_bus_data", data, w.d);
      end
    end
  end

  function automatic int clamp(input int len);
    return (len > 8) ? 8 : len;
  endfunction

  task automatic start_req(input logic w, input logic [10:0] addr, input logic [3:0] len,
                           output int acc);
    int n;
    @(negedge clk);
    bus_if.reqValid = 1'b1;
    bus_if.reqWrite = w;
    bus_if.reqAddr  = addr;
    bus_if.reqLen   = len;
    n = 0;
    #1;
    while (!bus_if.reqReady && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_accept", 64'(bus_if.reqReady), 64'd1);
    acc = cyc;
    @(negedge clk);
    bus_if.reqValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rd_q.size() + wr_q.size() + done_q.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(rd_q.size() + wr_q.size() + done_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input logic [10:0] addr, input int len, input int base,
                          input int stall_at, input int stall_n);
    int eff, a, n;
    logic [10:0] wa;
    eff = clamp(len);
    for (int i = 0; i < eff; i++) begin
      wa = addr + 11'(i);
      wr_q.push_back('{a: wa, d: mkword(base + i)});
      exp_mem[wa] = mkword(base + i);
    end
    start_req(1'b1, addr, 4'(len), a);
    done_q.push_back(a + eff + stall_n + 2);
    for (int i = 0; i < eff; i++) begin
      if (i == stall_at && stall_n > 0) begin
        bus_if.wrValid = 1'b0;
        bus_if.wrData  = 64'hA5A5_A5A5_A5A5_A5A5;
        for (int s = 0; s < stall_n; s++) begin
          #1;
          chk("stall_isReading", 64'(bus_if.isReading), 64'd1);
          chk("stall_reqReady", 64'(bus_if.reqReady), 64'd0);
          @(negedge clk);
        end
      end
      bus_if.wrValid = 1'b1;
      bus_if.wrData  = mkword(base + i);
      n = 0;
      #1;
      while (!bus_if.wrReady && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("wr_ready", 64'(bus_if.wrReady), 64'd1);
      @(negedge clk);
    end
    // Keep offering words past the burst end: none may reach the RAM.
    bus_if.wrValid = 1'b1;
    bus_if.wrData  = mkword(999);
    repeat (3) @(negedge clk);
    bus_if.wrValid = 1'b0;
    drain();
  endtask

  task automatic do_read(input logic [10:0] addr, input int len);
    int eff, a;
    logic [10:0] ra;
    eff = clamp(len);
    start_req(1'b0, addr, 4'(len), a);
    for (int i = 0; i < eff; i++) begin
      ra = addr + 11'(i);
      rd_q.push_back('{d: exp_mem[ra], last: (i == eff - 1), c: a + 3 + i});
    end
    done_q.push_back(a + eff + 2);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, mism, a;
    bus_if.reqValid = 1'b0;
    bus_if.reqWrite = 1'b0;
    bus_if.reqAddr  = '0;
    bus_if.reqLen   = '0;
    bus_if.wrValid  = 1'b0;
    bus_if.wrData   = '0;
    for (int i = 0; i < 2048; i++) exp_mem[i] = init_word(i);

    repeat (3) @(negedge clk);
    ram_init = 1'b0;
    #1;
    chk("rst_rdValid", 64'(bus_if.rdValid), 64'd0);
    chk("rst_rdLast", 64'(bus_if.rdLast), 64'd0);
    chk("rst_done", 64'(bus_if.done), 64'd0);
    chk("rst_rdData", bus_if.rdData, 64'd0);
    chk("rst_address", 64'(bus_if.address), 64'd0);
    chk("rst_isReading", 64'(bus_if.isReading), 64'd1);
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_reqReady", 64'(bus_if.reqReady), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    do_write(11'h010, 3, 1, -1, 0);
    do_read(11'h010, 3);

    do_write(11'h7FE, 4, 10, -1, 0);
    do_read(11'h7FE, 4);

    do_write(11'h200, 4, 20, 2, 2);
    do_read(11'h200, 4);

    do_write(11'h300, 0, 40, -1, 0);
    do_read(11'h300, 0);

    do_write(11'h400, 12, 30, -1, 0);
    do_read(11'h400, 12);

    // Reset after two of five words; no done and no further writes expected.
    for (int i = 0; i < 2; i++) begin
      wr_q.push_back('{a: 11'h100 + 11'(i), d: mkword(50 + i)});
      exp_mem[11'h100 + 11'(i)] = mkword(50 + i);
    end
    start_req(1'b1, 11'h100, 4'd5, a);
    for (int i = 0; i < 2; i++) begin
      bus_if.wrValid = 1'b1;
      bus_if.wrData  = mkword(50 + i);
      #1;
      chk("rstwr_ready", 64'(bus_if.wrReady), 64'd1);
      @(negedge clk);
    end
    bus_if.wrData = mkword(52);
    reset = 1'b1;
    #1;
    chk("rstwr_isReading", 64'(bus_if.isReading), 64'd1);
    chk("rstwr_busy", 64'(bus_if.busy), 64'd0);
    chk("rstwr_wrReady", 64'(bus_if.wrReady), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_if.wrValid = 1'b0;
    repeat (4) @(negedge clk);
    do_read(11'h100, 3);

    // Idle hygiene with the RAM output disabled: only the master could drive.
    ram_out_en     = 1'b0;
    bus_if.wrValid = 1'b1;
    bus_if.wrData  = 64'hA5A5_A5A5_A5A5_A5A5;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (bus_if.isReading !== 1'b1 || data === bus_if.wrData) bad++;
    end
    chk("idle_hygiene", 64'(bad), 64'd0);
    bus_if.wrValid = 1'b0;
    ram_out_en     = 1'b1;
    repeat (2) @(negedge clk);

    mism = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== exp_mem[i]) mism++;
    chk("ram_contents", 64'(mism), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
